// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_fifo_if : consumer-side handshake and status bundle of uart_rx_fifo.
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_avail;
  logic                 rx_ack;
  logic [CNT_W-1:0]     rx_count;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;
  logic                 err_clr;

  modport master (
    output rx_data, rx_avail, rx_count, frame_err, parity_err, overrun_err,
    input  rx_ack, err_clr
  );

  modport slave (
    input  rx_data, rx_avail, rx_count, frame_err, parity_err, overrun_err,
    output rx_ack, err_clr
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_fifo : oversampled UART receiver feeding a show-ahead receive FIFO.
// Macro UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote around mid-bit. Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 115200,
  parameter int OVERSAMPLE     = 16,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int FIFO_DEPTH     = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       uart_rxd,
  uart_rx_fifo_if.master  bus
);
  localparam int BAUD_X  = uart_baud_rate * OVERSAMPLE;
  localparam int DIV_RAW = (clk_freq + BAUD_X / 2) / BAUD_X;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCK_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [TCK_W-1:0] MID  = TCK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCK_W-1:0] LAST = TCK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic rxd_meta, rxd_sync, rxd_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  state_t               state;
  logic                 brk;
  logic                 start_det;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [TCK_W-1:0]     tick_cnt;
  logic                 bit_evt;
  logic                 bit_val;

  assign start_det = (state == IDLE) && !brk && rxd_prev && !rxd_sync;
  assign tick      = (div_cnt == DIV_W'(DIV - 1));

  // Restarting on the start edge phase-aligns every bit sample to that edge.
  always_ff @(posedge clk) begin
    if (rst || start_det) div_cnt <= '0;
    else if (tick)        div_cnt <= '0;
    else                  div_cnt <= div_cnt + 1'b1;
  end

`ifdef UART_RX_MAJORITY_EN
  logic smp0, smp1;
  always_ff @(posedge clk) begin
    if (rst) begin
      smp0 <= 1'b1;
      smp1 <= 1'b1;
    end else if (tick && tick_cnt == MID) begin
      smp0 <= rxd_sync;
    end else if (tick && tick_cnt == MID + 1'b1) begin
      smp1 <= rxd_sync;
    end
  end
  assign bit_evt = tick && (tick_cnt == MID + 2'd2);
  assign bit_val = (smp0 & smp1) | (smp0 & rxd_sync) | (smp1 & rxd_sync);
`else
  assign bit_evt = tick && (tick_cnt == MID);
  assign bit_val = rxd_sync;
`endif

  logic [DATA_BITS-1:0] shreg;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 par_acc, par_bad;
  logic                 push_stb, ferr_stb, perr_stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      brk      <= 1'b0;
      tick_cnt <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      par_acc  <= 1'b0;
      par_bad  <= 1'b0;
      push_stb <= 1'b0;
      ferr_stb <= 1'b0;
      perr_stb <= 1'b0;
    end else begin
      push_stb <= 1'b0;
      ferr_stb <= 1'b0;
      perr_stb <= 1'b0;
      if (start_det)  tick_cnt <= '0;
      else if (tick)  tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (brk && rxd_sync) brk <= 1'b0;
          if (start_det) state <= START;
        end
        START: if (bit_evt) begin
          if (bit_val) begin
            state <= IDLE;
          end else begin
            state   <= DATA;
            bit_cnt <= '0;
            par_acc <= 1'b0;
            par_bad <= 1'b0;
          end
        end
        DATA: if (bit_evt) begin
          shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
          par_acc <= par_acc ^ bit_val;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) state <= (PARITY != 0) ? PAR : STOP;
        end
        PAR: if (bit_evt) begin
          par_bad <= (PARITY == 1) ? ~(par_acc ^ bit_val) : (par_acc ^ bit_val);
          state   <= STOP;
        end
        STOP: if (bit_evt) begin
          state <= IDLE;
          if (!bit_val) begin
            ferr_stb <= 1'b1;
            brk      <= 1'b1;
          end else if (par_bad) begin
            perr_stb <= 1'b1;
          end else begin
            push_stb <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Extra stage so occupancy becomes visible two clocks after the stop sample.
  logic                 push_q;
  logic [DATA_BITS-1:0] push_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      push_q    <= 1'b0;
      push_data <= '0;
    end else begin
      push_q <= push_stb;
      if (push_stb) push_data <= shreg;
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full, pop, wr, ovr_evt;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = bus.rx_ack && (count != '0);
  assign wr      = push_q && (!full || pop);
  assign ovr_evt = push_q && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic frame_err, parity_err, overrun_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        frame_err   <= 1'b0;
        parity_err  <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (ferr_stb) frame_err   <= 1'b1;
      if (perr_stb) parity_err  <= 1'b1;
      if (ovr_evt)  overrun_err <= 1'b1;
    end
  end

  assign bus.rx_data     = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.rx_avail    = (count != '0);
  assign bus.rx_count    = count;
  assign bus.frame_err   = frame_err;
  assign bus.parity_err  = parity_err;
  assign bus.overrun_err = overrun_err;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo : directed bench for uart_rx_fifo (8N1 and 8E1 instances).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;
  localparam int BIT_CLKS = 432;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 274;
`else
  localparam int LAT = 220;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;
  logic sel = 1'b0;
  logic rxd_a, rxd_b;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [9:0] fr;

  always #10 clk = ~clk;

  assign rxd_a = sel ? 1'b1 : line;
  assign rxd_b = sel ? line : 1'b1;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_a ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_b ();

  uart_rx_fifo #(.PARITY(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .uart_rxd(rxd_a), .bus(bus_a)
  );
  uart_rx_fifo #(.PARITY(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .uart_rxd(rxd_b), .bus(bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_bit(input logic v);
    line = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Frame starts on the current negedge; LAT/LAT+1 straddle the FIFO update.
  task automatic send_frame(input logic [7:0] d, input bit use_par, input logic pbit,
                            input logic sbit, input bit chk);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    if (use_par) hold_bit(pbit);
    line = sbit;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(negedge clk);
      if (chk && k == LAT)     check("latency_before", bus_a.rx_avail, 0);
      if (chk && k == LAT + 1) check("latency_after", bus_a.rx_avail, 1);
    end
    line = 1'b1;
    repeat (sbit ? 16 : BIT_CLKS) @(negedge clk);
  endtask

  task automatic pop_a(input logic [7:0] exp);
    check("pop_data_a", bus_a.rx_data, exp);
    bus_a.rx_ack = 1'b1;
    @(negedge clk);
    bus_a.rx_ack = 1'b0;
  endtask

  initial begin
    bus_a.rx_ack = 1'b0; bus_a.err_clr = 1'b0;
    bus_b.rx_ack = 1'b0; bus_b.err_clr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_avail", bus_a.rx_avail, 0);
    check("reset_count", bus_a.rx_count, 0);
    check("reset_data", bus_a.rx_data, 0);
    check("reset_errs", {bus_a.frame_err, bus_a.parity_err, bus_a.overrun_err}, 0);

    // basic 8N1 receive with exact visibility latency
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    check("basic_data", bus_a.rx_data, 8'hA5);
    check("basic_count", bus_a.rx_count, 1);
    pop_a(8'hA5);
    check("basic_avail_after_pop", bus_a.rx_avail, 0);
    check("basic_count_after_pop", bus_a.rx_count, 0);

    // burst with pointer wrap
    for (int v = 1; v <= 4; v++) send_frame(8'(v), 1'b0, 1'b0, 1'b1, 1'b0);
    check("burst_count4", bus_a.rx_count, 4);
    pop_a(8'h01);
    pop_a(8'h02);
    send_frame(8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h06, 1'b0, 1'b0, 1'b1, 1'b0);
    check("wrap_count4", bus_a.rx_count, 4);
    pop_a(8'h03);
    pop_a(8'h04);
    pop_a(8'h05);
    pop_a(8'h06);
    check("wrap_empty", bus_a.rx_count, 0);

    // overrun
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_flag", bus_a.overrun_err, 1);
    check("ovr_count", bus_a.rx_count, 4);
    bus_a.err_clr = 1'b1;
    @(negedge clk);
    bus_a.err_clr = 1'b0;
    check("ovr_cleared", bus_a.overrun_err, 0);
    pop_a(8'h01);
    pop_a(8'h02);
    pop_a(8'h03);
    pop_a(8'h04);
    check("ovr_empty", bus_a.rx_avail, 0);

    // even parity instance
    sel = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    check("par_err", bus_b.parity_err, 1);
    check("par_frame_clear", bus_b.frame_err, 0);
    check("par_no_push", bus_b.rx_count, 0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    check("frame_err", bus_b.frame_err, 1);
    check("frame_no_push", bus_b.rx_count, 0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
    check("par_valid_count", bus_b.rx_count, 1);
    check("par_valid_data", bus_b.rx_data, 8'h33);
    sel = 1'b0;

    // short glitch on an idle line
    line = 1'b0;
    repeat (100) @(negedge clk);
    line = 1'b1;
    repeat (1000) @(negedge clk);
    check("glitch_count", bus_a.rx_count, 0);
    check("glitch_errs", {bus_a.frame_err, bus_a.parity_err, bus_a.overrun_err}, 0);

    // reset during data bit 3
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b0);
    hold_bit(1'b1);
    line = 1'b0;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    line = 1'b1;
    repeat (1000) @(negedge clk);
    check("rst_mid_count", bus_a.rx_count, 0);
    check("rst_mid_avail", bus_a.rx_avail, 0);
    check("rst_par_cleared", bus_b.parity_err, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    check("after_rst_count", bus_a.rx_count, 1);
    pop_a(8'h3C);

`ifdef UART_RX_MAJORITY_EN
    // one-clock inversion exactly at the first mid-bit sample of every bit
    fr = {1'b1, 8'h96, 1'b0};
    for (int b = 0; b < 10; b++) begin
      line = fr[b];
      repeat (216) @(negedge clk);
      line = ~fr[b];
      @(negedge clk);
      line = fr[b];
      repeat (215) @(negedge clk);
    end
    line = 1'b1;
    repeat (100) @(negedge clk);
    check("maj_count", bus_a.rx_count, 1);
    check("maj_errs", {bus_a.frame_err, bus_a.parity_err, bus_a.overrun_err}, 0);
    pop_a(8'h96);
`else
    fr = '1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
